// File: rtl/bp_pkg.sv
// Shared helpers for the local-history predictor: index widths, counter
// reset value, saturating counter step and PHT index hashing.
package bp_pkg;

  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Weakly not-taken value: just below the taken threshold
  function automatic logic [3:0] weak_nt(input int cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  function automatic logic [3:0] sat_update(input logic [3:0] cnt, input int cnt_w,
                                            input logic up);
    logic [3:0] maxv;
    maxv = 4'((1 << cnt_w) - 1);
    if (up) return (cnt == maxv) ? cnt : cnt + 4'd1;
    else    return (cnt == 4'd0) ? cnt : cnt - 4'd1;
  endfunction

  function automatic logic [31:0] pht_index(input logic [31:0] hist, input logic [31:0] pc,
                                            input int hist_w, input int hash);
    logic [31:0] mask;
    mask = 32'((64'd1 << hist_w) - 64'd1);
    return (hash != 0) ? ((hist ^ (pc >> 2)) & mask) : (hist & mask);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: saturating counters with a combinational read port
// and one saturating write port; synchronous reset to weakly not-taken.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_up_i
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(weak_nt(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] wr_cnt_d;

  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    wr_cnt_d = CNT_W'(sat_update(4'(cnt_q[wr_idx_i]), CNT_W, wr_up_i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= RST_CNT;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/local_hist_predictor.sv
// Two-level local-history branch predictor (BHT of per-branch histories feeding
// a PHT of saturating counters). Define LOCAL_PRED_STATS_EN to build the stat counters.
module local_hist_predictor
  import bp_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int HIST_W    = 4,
  parameter int CNT_W     = 2,
  parameter int PHT_HASH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcF,
  output logic              pred_takenF,
  output logic [HIST_W-1:0] pred_histF,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_pred,
  input  logic              update_taken,
  output logic              mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispreds
);

  localparam int BIDX_W = idx_w(BHT_DEPTH);

  logic [HIST_W-1:0] bht_q [BHT_DEPTH];
  logic [BIDX_W-1:0] bidx_f, bidx_u;
  logic [HIST_W-1:0] pidx_f, pidx_u, hist_d;
  logic [CNT_W-1:0]  rd_cnt;

  assign bidx_f      = pcF[BIDX_W+1:2];
  assign bidx_u      = update_pc[BIDX_W+1:2];
  assign pred_histF  = bht_q[bidx_f];
  assign pidx_f      = HIST_W'(pht_index(32'(pred_histF), pcF, HIST_W, PHT_HASH));
  // Training uses the history carried down the pipe, not the live BHT entry
  assign pidx_u      = HIST_W'(pht_index(32'(update_hist), update_pc, HIST_W, PHT_HASH));
  assign pred_takenF = (4'(rd_cnt) > weak_nt(CNT_W));
  assign mispredict  = update_en & (update_taken ^ update_pred);

  always_comb begin
    hist_d = HIST_W'({bht_q[bidx_u], update_taken});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= '0;
    end else if (update_en) begin
      bht_q[bidx_u] <= hist_d;
    end
  end

  bp_sat_counter_table #(
    .IDX_W (HIST_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx_i (pidx_f),
    .rd_cnt_o (rd_cnt),
    .wr_en_i  (update_en),
    .wr_idx_i (pidx_u),
    .wr_up_i  (update_taken)
  );

`ifdef LOCAL_PRED_STATS_EN
  logic [31:0] stat_branches_q, stat_mispreds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispreds_q <= '0;
    end else if (update_en) begin
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict && (stat_mispreds_q != '1)) stat_mispreds_q <= stat_mispreds_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispreds = stat_mispreds_q;
`else
  assign stat_branches = '0;
  assign stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_local_hist_predictor.sv
// Scoreboard bench for local_hist_predictor: a driver pushes expected lookups from an
// array-based reference model, and a negedge monitor pops and compares them.
module tb_local_hist_predictor;

  localparam int NB = 16;
  localparam int NP = 16;
  localparam int CMAX = 3;
  localparam int HASH = 0;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        pred_takenF;
  logic [3:0]  pred_histF;
  logic        update_en;
  logic [31:0] update_pc;
  logic [3:0]  update_hist;
  logic        update_pred;
  logic        update_taken;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispreds;

  typedef struct {
    logic [3:0]  hist;
    logic        taken;
    logic        misp;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;

  int          mBht[NB];
  int          mPht[NP];
  int unsigned mB, mM;

  local_hist_predictor #(
    .BHT_DEPTH (16),
    .HIST_W    (4),
    .CNT_W     (2),
    .PHT_HASH  (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcF           (pcF),
    .pred_takenF   (pred_takenF),
    .pred_histF    (pred_histF),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_hist   (update_hist),
    .update_pred   (update_pred),
    .update_taken  (update_taken),
    .mispredict    (mispredict),
    .stat_branches (stat_branches),
    .stat_mispreds (stat_mispreds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bIdx(input logic [31:0] pc);
    return int'((pc >> 2) % NB);
  endfunction

  function automatic int pIdx(input int hist, input logic [31:0] pc);
    return (HASH != 0) ? ((hist ^ int'((pc >> 2) % NP)) % NP) : hist;
  endfunction

  function automatic logic [3:0] mHist(input logic [31:0] pc);
    return 4'(mBht[bIdx(pc)]);
  endfunction

  function automatic logic mPred(input logic [31:0] pc);
    return mPht[pIdx(int'(mHist(pc)), pc)] >= 2;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NB; i++) mBht[i] = 0;
    for (int i = 0; i < NP; i++) mPht[i] = 1;
    mB = 0;
    mM = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, record the expected response, then advance the model at the edge
  task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic en,
                               input logic [31:0] upc, input logic [3:0] uh,
                               input logic up, input logic ut, input bit chk);
    exp_t e;
    int   b, p;
    rst = r; pcF = pc; update_en = en; update_pc = upc;
    update_hist = uh; update_pred = up; update_taken = ut;
    if (chk) begin
      e.hist  = mHist(pc);
      e.taken = mPred(pc);
      e.misp  = en && (ut != up);
`ifdef LOCAL_PRED_STATS_EN
      e.sb = mB;
      e.sm = mM;
`else
      e.sb = 32'd0;
      e.sm = 32'd0;
`endif
      expQ.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      modelReset();
    end else if (en) begin
      b = bIdx(upc);
      p = pIdx(int'(uh), upc);
      mBht[b] = (mBht[b] * 2 + int'(ut)) % NP;
      if (ut && mPht[p] < CMAX) mPht[p]++;
      else if (!ut && mPht[p] > 0) mPht[p]--;
      if (mB != 32'hFFFFFFFF) mB++;
      if ((ut != up) && mM != 32'hFFFFFFFF) mM++;
    end
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    applyStimulus(1'b0, pc, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic [3:0] uh,
                     input logic up, input logic ut);
    applyStimulus(1'b0, pc, 1'b1, upc, uh, up, ut, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("pred_histF", 32'(pred_histF), 32'(e.hist));
      checkOutput("pred_takenF", 32'(pred_takenF), 32'(e.taken));
      checkOutput("mispredict", 32'(mispredict), 32'(e.misp));
      checkOutput("stat_branches", stat_branches, e.sb);
      checkOutput("stat_mispreds", stat_mispreds, e.sm);
    end
  end

  initial begin
    logic [31:0] fpc, npc;
    logic [3:0]  fh;
    logic        fp, fv, t;

    rst = 1'b1; pcF = '0; update_en = 1'b0; update_pc = '0;
    update_hist = '0; update_pred = 1'b0; update_taken = 1'b0;
    modelReset();
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset sweep");
    for (int i = 0; i < 16; i++) lookup(32'h0040_0000 + 32'(i * 4));

    $display("[TB] saturation and same-cycle hazard");
    upd(32'h0, 32'h10, 4'd0, 1'b0, 1'b1);
    upd(32'h0, 32'h10, 4'd0, 1'b0, 1'b1);
    upd(32'h10, 32'h10, 4'd0, 1'b1, 1'b1);
    lookup(32'h10);
    lookup(32'h50);
    upd(32'h0, 32'h10, 4'd0, 1'b1, 1'b0);
    lookup(32'h0);
    upd(32'h0, 32'h10, 4'd0, 1'b1, 1'b0);
    lookup(32'h0);

    $display("[TB] reset priority over update");
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h10, 4'd0, 1'b0, 1'b1, 1'b1);
    lookup(32'h10);
    lookup(32'h50);
    lookup(32'h0);

    $display("[TB] loop pattern TTTN");
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 4; k++) begin
        fh = mHist(32'h20);
        fp = mPred(32'h20);
        lookup(32'h20);
        upd(32'h0, 32'h20, fh, fp, (k != 3));
      end
    end

    $display("[TB] aliasing through bidx 4");
    applyStimulus(1'b1, 32'h0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      fh = mHist(32'h10);
      fp = mPred(32'h10);
      upd(32'h50, 32'h10, fh, fp, 1'b1);
    end
    lookup(32'h50);

    $display("[TB] statistics");
    applyStimulus(1'b1, 32'h0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    upd(32'h0, 32'h40, 4'd0, 1'b1, 1'b1);
    upd(32'h0, 32'h44, 4'd0, 1'b0, 1'b1);
    upd(32'h0, 32'h48, 4'd0, 1'b0, 1'b0);
    upd(32'h0, 32'h4C, 4'd0, 1'b1, 1'b0);
    upd(32'h0, 32'h40, 4'd1, 1'b1, 1'b1);
    lookup(32'h0);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    lookup(32'h0);

    $display("[TB] randomized pipelined traffic");
    fv = 1'b0; fpc = '0; fh = '0; fp = 1'b0;
    for (int i = 0; i < 400; i++) begin
      npc = 32'h0040_0000 + (32'($urandom_range(0, 31)) << 2);
      t   = ($urandom_range(0, 3) != 0);
      if (i == 200) begin
        applyStimulus(1'b1, npc, fv, fpc, fh, fp, t, 1'b1);
        fv = 1'b0;
      end else begin
        applyStimulus(1'b0, npc, fv, fpc, fh, fp, t, 1'b1);
        fv  = ($urandom_range(0, 4) != 0);
        fpc = npc;
        fh  = mHist(npc);
        fp  = mPred(npc);
      end
    end

    lookup(32'h0);
    @(negedge clk); #1;
    checkOutput("queueDrain", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
